// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer write path: geometry, the
// fill-engine state encoding and the {y,x} address packing helper.
package vga_pkg;

    localparam int COORD_W   = 8;
    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 8;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    // Framebuffer rows are 256 bytes wide, so the address is simply {y, x}.
    function automatic logic [FB_ADDR_W-1:0] packAddr(
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] x
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/vga_fill_engine.sv
// Rectangle fill engine: walks a w x h block row by row, presenting one
// pixel write at a time on a valid/ready interface. Coordinates wrap mod 256.
module vga_fill_engine
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [COORD_W-1:0]    i_x,
    input  logic [COORD_W-1:0]    i_y,
    input  logic [COORD_W-1:0]    i_w,
    input  logic [COORD_W-1:0]    i_h,
    input  logic [DATA_WIDTH-1:0] i_color,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FB_ADDR_W-1:0]  o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    fill_state_t           r_state, w_state_nxt;
    logic [COORD_W-1:0]    r_x0, r_y0, r_w, r_h, r_cx, r_cy;
    logic [COORD_W-1:0]    w_x0_nxt, w_y0_nxt, w_w_nxt, w_h_nxt, w_cx_nxt, w_cy_nxt;
    logic [DATA_WIDTH-1:0] r_color, w_color_nxt;
    logic [COORD_W-1:0]    w_px, w_py;

    // State and rectangle registers; reset abandons any fill in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x0    <= w_x0_nxt;
            r_y0    <= w_y0_nxt;
            r_w     <= w_w_nxt;
            r_h     <= w_h_nxt;
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_color <= w_color_nxt;
        end
    end

    // Next-state logic: latch on start (IDLE only), step cx/cy per granted pixel.
    always_comb begin
        w_state_nxt = r_state;
        w_x0_nxt    = r_x0;
        w_y0_nxt    = r_y0;
        w_w_nxt     = r_w;
        w_h_nxt     = r_h;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_color_nxt = r_color;
        unique case (r_state)
            FILL_IDLE: begin
                if (i_start) begin
                    w_x0_nxt    = i_x;
                    w_y0_nxt    = i_y;
                    w_w_nxt     = i_w;
                    w_h_nxt     = i_h;
                    w_color_nxt = i_color;
                    w_cx_nxt    = '0;
                    w_cy_nxt    = '0;
                    if ((i_w == '0) || (i_h == '0)) begin
                        w_state_nxt = FILL_DONE;
                    end else begin
                        w_state_nxt = FILL_RUN;
                    end
                end
            end
            FILL_RUN: begin
                if (i_ready) begin
                    if (r_cx == (r_w - COORD_W'(1))) begin
                        w_cx_nxt = '0;
                        if (r_cy == (r_h - COORD_W'(1))) begin
                            w_state_nxt = FILL_DONE;
                        end else begin
                            w_cy_nxt = r_cy + COORD_W'(1);
                        end
                    end else begin
                        w_cx_nxt = r_cx + COORD_W'(1);
                    end
                end
            end
            FILL_DONE: begin
                w_state_nxt = FILL_IDLE;
            end
            default: begin
                w_state_nxt = FILL_IDLE;
            end
        endcase
    end

    assign w_px    = r_x0 + r_cx;
    assign w_py    = r_y0 + r_cy;
    assign o_valid = (r_state == FILL_RUN);
    assign o_addr  = packAddr(w_py, w_px);
    assign o_data  = r_color;
    assign o_busy  = (r_state == FILL_RUN);
    assign o_done  = (r_state == FILL_DONE);

endmodule

// File: rtl/vga_fb_write_arb.sv
// Framebuffer port-A write controller: round-robin arbitration between two
// external pixel writers and the fill engine, with a registered write port.
module vga_fb_write_arb
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_W,
    parameter int ADDR_WIDTH = FB_ADDR_W,
    parameter int COORD_W    = vga_pkg::COORD_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_w0_valid,
    input  logic [ADDR_WIDTH-1:0] i_w0_addr,
    input  logic [DATA_WIDTH-1:0] i_w0_data,
    output logic                  o_w0_ready,
    input  logic                  i_w1_valid,
    input  logic [ADDR_WIDTH-1:0] i_w1_addr,
    input  logic [DATA_WIDTH-1:0] i_w1_data,
    output logic                  o_w1_ready,
    input  logic                  i_fill_start,
    input  logic [COORD_W-1:0]    i_fill_x,
    input  logic [COORD_W-1:0]    i_fill_y,
    input  logic [COORD_W-1:0]    i_fill_w,
    input  logic [COORD_W-1:0]    i_fill_h,
    input  logic [DATA_WIDTH-1:0] i_fill_color,
    output logic                  o_fill_busy,
    output logic                  o_fill_done,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data
);

    logic                  w_f_valid;
    logic [ADDR_WIDTH-1:0] w_f_addr;
    logic [DATA_WIDTH-1:0] w_f_data;
    logic [2:0]            w_req, w_grant;
    logic [1:0]            r_ptr, w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;

    vga_fill_engine #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fill (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_fill_start),
        .i_x     (i_fill_x),
        .i_y     (i_fill_y),
        .i_w     (i_fill_w),
        .i_h     (i_fill_h),
        .i_color (i_fill_color),
        .o_valid (w_f_valid),
        .i_ready (w_grant[2]),
        .o_addr  (w_f_addr),
        .o_data  (w_f_data),
        .o_busy  (o_fill_busy),
        .o_done  (o_fill_done)
    );

    assign w_req = {w_f_valid, i_w1_valid, i_w0_valid};

    // Round-robin pick: search begins at r_ptr, which names the source after the last winner.
    always_comb begin
        w_grant = 3'b000;
        unique case (r_ptr)
            2'd1: begin
                if      (w_req[1]) w_grant = 3'b010;
                else if (w_req[2]) w_grant = 3'b100;
                else if (w_req[0]) w_grant = 3'b001;
            end
            2'd2: begin
                if      (w_req[2]) w_grant = 3'b100;
                else if (w_req[0]) w_grant = 3'b001;
                else if (w_req[1]) w_grant = 3'b010;
            end
            default: begin
                if      (w_req[0]) w_grant = 3'b001;
                else if (w_req[1]) w_grant = 3'b010;
                else if (w_req[2]) w_grant = 3'b100;
            end
        endcase
    end

    // Pointer advance and write-data selection for the current winner.
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_sel_addr = r_mem_addr;
        w_sel_data = r_mem_data;
        if (w_grant[0]) begin
            w_ptr_nxt  = 2'd1;
            w_sel_addr = i_w0_addr;
            w_sel_data = i_w0_data;
        end else if (w_grant[1]) begin
            w_ptr_nxt  = 2'd2;
            w_sel_addr = i_w1_addr;
            w_sel_data = i_w1_data;
        end else if (w_grant[2]) begin
            w_ptr_nxt  = 2'd0;
            w_sel_addr = w_f_addr;
            w_sel_data = w_f_data;
        end
    end

    // Registered port A: a grant this cycle becomes a write strobe next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 2'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_mem_we   <= |w_grant;
            r_mem_addr <= w_sel_addr;
            r_mem_data <= w_sel_data;
        end
    end

    assign o_w0_ready = w_grant[0];
    assign o_w1_ready = w_grant[1];
    assign o_mem_we   = r_mem_we;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_data = r_mem_data;

endmodule

// File: tb/tb_vga_fb_write_arb.sv
// Directed self-checking bench for vga_fb_write_arb.
module tb_vga_fb_write_arb;

    logic        clk;
    logic        rst_n;
    logic        w0Valid, w1Valid, w0Ready, w1Ready;
    logic [15:0] w0Addr, w1Addr;
    logic [7:0]  w0Data, w1Data;
    logic        fillStart, fillBusy, fillDone;
    logic [7:0]  fillX, fillY, fillW, fillH, fillColor;
    logic        memWe;
    logic [15:0] memAddr;
    logic [7:0]  memData;

    int checkCount = 0;
    int errorCount = 0;

    logic [15:0] fillA [6] = '{16'h10FE, 16'h10FF, 16'h1000, 16'h11FE, 16'h11FF, 16'h1100};
    logic [15:0] fillB [6] = '{16'h2000, 16'h2001, 16'h2002, 16'h2100, 16'h2101, 16'h2102};

    vga_fb_write_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_w0_valid   (w0Valid),
        .i_w0_addr    (w0Addr),
        .i_w0_data    (w0Data),
        .o_w0_ready   (w0Ready),
        .i_w1_valid   (w1Valid),
        .i_w1_addr    (w1Addr),
        .i_w1_data    (w1Data),
        .o_w1_ready   (w1Ready),
        .i_fill_start (fillStart),
        .i_fill_x     (fillX),
        .i_fill_y     (fillY),
        .i_fill_w     (fillW),
        .i_fill_h     (fillH),
        .i_fill_color (fillColor),
        .o_fill_busy  (fillBusy),
        .o_fill_done  (fillDone),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_data   (memData)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                                 input logic [7:0] h, input logic [7:0] c);
        fillX     = x;
        fillY     = y;
        fillW     = w;
        fillH     = h;
        fillColor = c;
        fillStart = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        w0Valid = 1'b0; w1Valid = 1'b0;
        w0Addr = '0; w1Addr = '0; w0Data = '0; w1Data = '0;
        fillStart = 1'b0; fillX = '0; fillY = '0; fillW = '0; fillH = '0; fillColor = '0;

        // Reset values
        #2;
        checkOutput("rst_we",   16'(memWe),    16'h0);
        checkOutput("rst_addr", memAddr,       16'h0);
        checkOutput("rst_data", 16'(memData),  16'h0);
        checkOutput("rst_busy", 16'(fillBusy), 16'h0);
        checkOutput("rst_done", 16'(fillDone), 16'h0);
        #10 rst_n = 1'b1;
        tick();

        // Single writer
        $display("[TB] single writer");
        w0Valid = 1'b1; w0Addr = 16'h1234; w0Data = 8'h5A;
        #1;
        checkOutput("single_rdy0", 16'(w0Ready), 16'h1);
        checkOutput("single_rdy1", 16'(w1Ready), 16'h0);
        tick();
        w0Valid = 1'b0;
        checkOutput("single_we",   16'(memWe),   16'h1);
        checkOutput("single_addr", memAddr,      16'h1234);
        checkOutput("single_data", 16'(memData), 16'h5A);
        tick();
        checkOutput("single_we_off", 16'(memWe), 16'h0);
        checkOutput("single_hold",   memAddr,    16'h1234);

        // Contention from a fresh pointer
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        $display("[TB] contention");
        w0Valid = 1'b1; w0Addr = 16'h0100; w0Data = 8'h11;
        w1Valid = 1'b1; w1Addr = 16'h0200; w1Data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("cont_rdy0", 16'(w0Ready), (i % 2 == 0) ? 16'h1 : 16'h0);
            checkOutput("cont_rdy1", 16'(w1Ready), (i % 2 == 1) ? 16'h1 : 16'h0);
            tick();
            checkOutput("cont_we",   16'(memWe), 16'h1);
            checkOutput("cont_addr", memAddr, (i % 2 == 0) ? 16'h0100 : 16'h0200);
        end
        w0Valid = 1'b0; w1Valid = 1'b0;
        tick();
        checkOutput("cont_we_off", 16'(memWe), 16'h0);

        // Fill with x wrap, no other traffic
        $display("[TB] fill wrap");
        applyStimulus(8'hFE, 8'h10, 8'd3, 8'd2, 8'h07);
        #1;
        checkOutput("fill_busy_pre", 16'(fillBusy), 16'h0);
        tick();
        fillStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("fill_busy", 16'(fillBusy), 16'h1);
            tick();
            checkOutput("fill_we",   16'(memWe),   16'h1);
            checkOutput("fill_addr", memAddr,      fillA[i]);
            checkOutput("fill_data", 16'(memData), 16'h07);
        end
        checkOutput("fill_done",      16'(fillDone), 16'h1);
        checkOutput("fill_busy_done", 16'(fillBusy), 16'h0);
        tick();
        checkOutput("fill_done_off", 16'(fillDone), 16'h0);
        checkOutput("fill_busy_off", 16'(fillBusy), 16'h0);
        checkOutput("fill_we_off",   16'(memWe),    16'h0);

        // Fill interleaved with a continuously valid writer 0
        $display("[TB] fill with w0");
        applyStimulus(8'h00, 8'h20, 8'd3, 8'd2, 8'h33);
        tick();
        fillStart = 1'b0;
        w0Valid = 1'b1; w0Addr = 16'hABCD; w0Data = 8'h44;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) applyStimulus(8'h80, 8'h80, 8'd1, 8'd1, 8'hEE);
            #1;
            checkOutput("mix_rdy0", 16'(w0Ready), (i % 2 == 0) ? 16'h1 : 16'h0);
            tick();
            fillStart = 1'b0;
            checkOutput("mix_we",   16'(memWe), 16'h1);
            checkOutput("mix_addr", memAddr, (i % 2 == 0) ? 16'hABCD : fillB[i / 2]);
            checkOutput("mix_data", 16'(memData), (i % 2 == 0) ? 16'h44 : 16'h33);
        end
        w0Valid = 1'b0;
        checkOutput("mix_done", 16'(fillDone), 16'h1);
        tick();
        checkOutput("mix_done_off", 16'(fillDone), 16'h0);
        checkOutput("mix_busy_off", 16'(fillBusy), 16'h0);

        // Zero-size fill
        $display("[TB] zero size");
        applyStimulus(8'h05, 8'h05, 8'd0, 8'd5, 8'hFF);
        #1;
        checkOutput("zero_busy_pre", 16'(fillBusy), 16'h0);
        tick();
        fillStart = 1'b0;
        checkOutput("zero_done", 16'(fillDone), 16'h1);
        checkOutput("zero_busy", 16'(fillBusy), 16'h0);
        checkOutput("zero_we",   16'(memWe),    16'h0);
        tick();
        checkOutput("zero_done_off", 16'(fillDone), 16'h0);
        checkOutput("zero_busy_off", 16'(fillBusy), 16'h0);
        checkOutput("zero_we_off",   16'(memWe),    16'h0);

        // Reset in the middle of a fill
        $display("[TB] reset mid-fill");
        applyStimulus(8'h50, 8'h60, 8'd4, 8'd4, 8'h99);
        tick();
        fillStart = 1'b0;
        tick();
        checkOutput("mid_we_pre",   16'(memWe),    16'h1);
        checkOutput("mid_busy_pre", 16'(fillBusy), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_we",   16'(memWe),    16'h0);
        checkOutput("mid_busy", 16'(fillBusy), 16'h0);
        checkOutput("mid_done", 16'(fillDone), 16'h0);
        #2 rst_n = 1'b1;
        w0Valid = 1'b1; w0Addr = 16'h0F0F; w0Data = 8'hA5;
        w1Valid = 1'b1; w1Addr = 16'hF0F0; w1Data = 8'h5A;
        #1;
        checkOutput("post_rdy0", 16'(w0Ready), 16'h1);
        checkOutput("post_rdy1", 16'(w1Ready), 16'h0);
        tick();
        w0Valid = 1'b0; w1Valid = 1'b0;
        checkOutput("post_addr", memAddr, 16'h0F0F);
        applyStimulus(8'h50, 8'h60, 8'd2, 8'd1, 8'h5C);
        tick();
        fillStart = 1'b0;
        checkOutput("post_busy", 16'(fillBusy), 16'h1);
        tick();
        checkOutput("post_fill0",  memAddr,      16'h6050);
        checkOutput("post_color",  16'(memData), 16'h5C);
        tick();
        checkOutput("post_fill1",  memAddr,       16'h6051);
        checkOutput("post_done",   16'(fillDone), 16'h1);
        tick();
        checkOutput("post_done_off", 16'(fillDone), 16'h0);
        checkOutput("post_we_off",   16'(memWe),    16'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
